multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 124 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with optional performance counters.
//   clk                 sole clock, all state updates on the rising edge
//   reset               asynchronous active-high reset
//   opcode, funct       instruction fields [31:26] and [5:0] from the instruction register
//   pc_wr, ir_wr        PC update strobe / instruction register load strobe
//   grf_wr, dm_wr       register file write strobe / data memory write strobe
//   alu_op              00 add, 01 sub, 10 or
//   ext_op              00 zero-extend, 01 sign-extend, 10 imm<<16
//   npc_op              00 PC+4, 01 beq, 10 jal, 11 jr
//   m1_sel              write register: 00 rt, 01 rd, 10 $31
//   m2_sel              write data: 00 ALU, 01 DM, 10 EXT, 11 PC+4
//   m3_sel              ALU B operand: 0 rt, 1 EXT
//   state               FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4
//   illegal             high in DECODE for an unsupported encoding
//   retire_cnt          retired instructions, live only with MULTICYCLE_CTRL_PERF_EN
//   cycle_cnt           clock cycles, live only with MULTICYCLE_CTRL_PERF_EN
// Define MULTICYCLE_CTRL_PERF_EN to build the counters; otherwise they are constant 0.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        grf_wr,
    output logic        dm_wr,
    output logic [1:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic [1:0]  npc_op,
    output logic [1:0]  m1_sel,
    output logic [1:0]  m2_sel,
    output logic        m3_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retire_cnt,
    output logic [31:0] cycle_cnt
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   r_type, i_addu, i_subu, i_jr, i_nop;
    logic   i_ori, i_lw, i_sw, i_beq, i_lui, i_jal, legal, active;

    always_comb begin
        r_type = opcode == 6'b000000;
        i_addu = r_type && funct == 6'b100001;
        i_subu = r_type && funct == 6'b100011;
        i_jr   = r_type && funct == 6'b001000;
        i_nop  = r_type && funct == 6'b000000;
        i_ori  = opcode == 6'b001101;
        i_lw   = opcode == 6'b100011;
        i_sw   = opcode == 6'b101011;
        i_beq  = opcode == 6'b000100;
        i_lui  = opcode == 6'b001111;
        i_jal  = opcode == 6'b000011;
        legal  = i_addu || i_subu || i_jr || i_nop || i_ori || i_lw || i_sw || i_beq || i_lui || i_jal;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = i_jal ? WB : (i_nop || !legal) ? FETCH : EXEC;
            EXEC:    state_d = (i_lw || i_sw) ? MEM : (i_addu || i_subu || i_ori || i_lui) ? WB : FETCH;
            MEM:     state_d = i_lw ? WB : FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // The final state of every sequence is the one whose successor is FETCH,
    // so pc_wr fires exactly once per instruction. Selects are held from
    // DECODE onward and forced to 0 in FETCH and in unused state codes.
    always_comb begin
        active  = state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB;
        state   = state_q;
        ir_wr   = !reset && state_q == FETCH;
        pc_wr   = !reset && active && state_d == FETCH;
        grf_wr  = !reset && state_q == WB;
        dm_wr   = !reset && state_q == MEM && i_sw;
        illegal = state_q == DECODE && !legal;
        npc_op  = !pc_wr ? 2'b00 : i_beq ? 2'b01 : i_jal ? 2'b10 : i_jr ? 2'b11 : 2'b00;
        m1_sel  = !active ? 2'b00 : (i_addu || i_subu) ? 2'b01 : i_jal ? 2'b10 : 2'b00;
        m2_sel  = !active ? 2'b00 : i_lw ? 2'b01 : i_lui ? 2'b10 : i_jal ? 2'b11 : 2'b00;
        m3_sel  = active && (i_ori || i_lw || i_sw);
        alu_op  = !active ? 2'b00 : (i_subu || i_beq) ? 2'b01 : i_ori ? 2'b10 : 2'b00;
        ext_op  = !active ? 2'b00 : (i_lw || i_sw) ? 2'b01 : i_lui ? 2'b10 : 2'b00;
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, retire_cnt_q, retire_cnt_d;

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + 32'd1;
        retire_cnt_d = retire_cnt_q + {31'd0, pc_wr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        pc_wr, ir_wr, grf_wr, dm_wr, m3_sel, illegal;
    logic [1:0]  alu_op, ext_op, npc_op, m1_sel, m2_sel;
    logic [2:0]  state;
    logic [31:0] retire_cnt, cycle_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_LUI = 6'b001111, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000, F_NOP = 6'b000000;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .grf_wr(grf_wr), .dm_wr(dm_wr),
        .alu_op(alu_op), .ext_op(ext_op), .npc_op(npc_op),
        .m1_sel(m1_sel), .m2_sel(m2_sel), .m3_sel(m3_sel),
        .state(state), .illegal(illegal),
        .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic exp_cyc(input string tag, input logic [2:0] st, input logic iw, input logic pw,
                           input logic gw, input logic dw);
        chk(tag, "state", {29'd0, state}, {29'd0, st});
        chk(tag, "ir_wr", {31'd0, ir_wr}, {31'd0, iw});
        chk(tag, "pc_wr", {31'd0, pc_wr}, {31'd0, pw});
        chk(tag, "grf_wr", {31'd0, grf_wr}, {31'd0, gw});
        chk(tag, "dm_wr", {31'd0, dm_wr}, {31'd0, dw});
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        opcode = OP_R;
        funct = F_ADDU;
        #3;
        exp_cyc("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst", "cycle_cnt", cycle_cnt, 32'd0);
        chk("rst", "retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        // addu: F-D-E-W
        exp_cyc("addu_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("addu_F", "m1_sel", {30'd0, m1_sel}, 32'd0);
        next;
        exp_cyc("addu_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addu_D", "m1_sel", {30'd0, m1_sel}, 32'd1);
        chk("addu_D", "illegal", {31'd0, illegal}, 32'd0);
        next;
        exp_cyc("addu_E", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("addu_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("addu_W", "m1_sel", {30'd0, m1_sel}, 32'd1);
        chk("addu_W", "m3_sel", {31'd0, m3_sel}, 32'd0);
        chk("addu_W", "alu_op", {30'd0, alu_op}, 32'd0);
        chk("addu_W", "npc_op", {30'd0, npc_op}, 32'd0);
        next;
        // subu: alu_op 01
        funct = F_SUBU;
        exp_cyc("subu_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        chk("subu_D", "alu_op", {30'd0, alu_op}, 32'd1);
        next;
        next;
        exp_cyc("subu_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        next;
        // lw: F-D-E-M-W
        opcode = OP_LW;
        exp_cyc("lw_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lw_F", "ext_op", {30'd0, ext_op}, 32'd0);
        next;
        exp_cyc("lw_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("lw_E", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_E", "ext_op", {30'd0, ext_op}, 32'd1);
        chk("lw_E", "m3_sel", {31'd0, m3_sel}, 32'd1);
        next;
        exp_cyc("lw_M", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("lw_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lw_W", "m2_sel", {30'd0, m2_sel}, 32'd1);
        next;
        // sw: F-D-E-M
        opcode = OP_SW;
        exp_cyc("sw_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("sw_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("sw_E", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("sw_M", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sw_M", "ext_op", {30'd0, ext_op}, 32'd1);
        next;
        // beq: F-D-E, npc 01 on last cycle
        opcode = OP_BEQ;
        exp_cyc("beq_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("beq_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("beq_D", "npc_op", {30'd0, npc_op}, 32'd0);
        next;
        exp_cyc("beq_E", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("beq_E", "npc_op", {30'd0, npc_op}, 32'd1);
        chk("beq_E", "alu_op", {30'd0, alu_op}, 32'd1);
        next;
        // jal: F-D-W
        opcode = OP_JAL;
        exp_cyc("jal_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("jal_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jal_D", "npc_op", {30'd0, npc_op}, 32'd0);
        next;
        exp_cyc("jal_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("jal_W", "npc_op", {30'd0, npc_op}, 32'd2);
        chk("jal_W", "m1_sel", {30'd0, m1_sel}, 32'd2);
        chk("jal_W", "m2_sel", {30'd0, m2_sel}, 32'd3);
        next;
        // jr: F-D-E, npc 11
        opcode = OP_R;
        funct = F_JR;
        exp_cyc("jr_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("jr_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("jr_E", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jr_E", "npc_op", {30'd0, npc_op}, 32'd3);
        next;
        // ori and lui: F-D-E-W
        opcode = OP_ORI;
        next;
        chk("ori_D", "alu_op", {30'd0, alu_op}, 32'd2);
        chk("ori_D", "m3_sel", {31'd0, m3_sel}, 32'd1);
        next;
        next;
        exp_cyc("ori_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ori_W", "ext_op", {30'd0, ext_op}, 32'd0);
        next;
        opcode = OP_LUI;
        next;
        next;
        next;
        exp_cyc("lui_W", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lui_W", "ext_op", {30'd0, ext_op}, 32'd2);
        chk("lui_W", "m2_sel", {30'd0, m2_sel}, 32'd2);
        next;
        // nop: F-D
        opcode = OP_R;
        funct = F_NOP;
        next;
        exp_cyc("nop_D", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nop_D", "illegal", {31'd0, illegal}, 32'd0);
        next;
        // illegal opcode: F-D with pc_wr in D
        opcode = OP_BAD;
        exp_cyc("bad_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bad_F", "illegal", {31'd0, illegal}, 32'd0);
        next;
        exp_cyc("bad_D", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bad_D", "illegal", {31'd0, illegal}, 32'd1);
        chk("bad_D", "npc_op", {30'd0, npc_op}, 32'd0);
        next;
        exp_cyc("bad_next", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // reset in MEM of lw
        opcode = OP_LW;
        next;
        next;
        next;
        chk("lwr_M", "state", {29'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        exp_cyc("lwr_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lwr_rst", "cycle_cnt", cycle_cnt, 32'd0);
        chk("lwr_rst", "retire_cnt", retire_cnt, 32'd0);
        next;
        exp_cyc("lwr_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        exp_cyc("lwr_F", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next;
        exp_cyc("lwr_D", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        next;
        exp_cyc("lwr_M2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        next;
        // reset in WB of lw drops grf_wr at once
        reset = 1'b1;
        #1;
        exp_cyc("lwwb_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        // reset in MEM of sw drops dm_wr at once
        opcode = OP_SW;
        next;
        next;
        next;
        chk("swr_M", "dm_wr", {31'd0, dm_wr}, 32'd1);
        reset = 1'b1;
        #1;
        exp_cyc("swr_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        // ten back-to-back addu
        opcode = OP_R;
        funct = F_ADDU;
        for (int i = 0; i < 10; i++) repeat (4) next;
        exp_cyc("perf_end", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("perf", "cycle_cnt", cycle_cnt, 32'd40);
        chk("perf", "retire_cnt", retire_cnt, 32'd10);
        funct = F_NOP;
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        release dut.retire_cnt_q;
        chk("wrap_pre", "cycle_cnt", cycle_cnt, 32'hFFFF_FFFF);
        next;
        chk("wrap", "cycle_cnt", cycle_cnt, 32'd0);
        chk("wrap", "retire_cnt", retire_cnt, 32'hFFFF_FFFF);
        exp_cyc("wrap_D", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        next;
        chk("wrap2", "cycle_cnt", cycle_cnt, 32'd1);
        chk("wrap2", "retire_cnt", retire_cnt, 32'd0);
`else
        chk("perf", "cycle_cnt", cycle_cnt, 32'd0);
        chk("perf", "retire_cnt", retire_cnt, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
